digiota_decimator: RTL and testbench
====================================

# digiota_decimator

Downstream consumer of the gate-level digital OTA/comparator output. Samples the asynchronous 1-bit comparator decision, synchronizes it into the `clk` domain, and counts ones over fixed windows of 2^WIN_LOG2 cycles. Each completed window count is presented on a single-entry valid/ready output register. Overruns are flagged with a sticky bit. Sits between the comparator core and the readout/serializer logic on `uo_out`.

## Interface
- `WIN_LOG2`, default 6: log2 of the window length in cycles; legal range 2..10.
- `OUT_W`, default `WIN_LOG2+1`: result width. Derived; never overridden.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cmp_in`  in  1: comparator output. Asynchronous to `clk`.
- `enable`  in  1: high = run windows; low = idle, partial window discarded.
- `sample_data`  out  OUT_W: ones-count of the last completed window, 0..2^WIN_LOG2.
- `sample_valid`  out  1: `sample_data` holds an unconsumed result.
- `sample_ready`  in  1: consumer accepts when `sample_valid && sample_ready`.
- `overrun`  out  1: sticky; set when a window result is dropped.
- `clear_ovr`  in  1: single-cycle pulse that clears `overrun`.
- `busy`  out  1: FSM is in RUN.

## Operation
- Synchronizer: two flops, `cmp_in` -> `s1` -> `s2`. Stage bit `b = s2`, or the filtered bit (see Configuration). Synchronizer and filter run whenever `rst` is low, independent of `enable`.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on an edge with `enable`=1: `cyc`<=0, `acc`<=0.
  - RUN -> IDLE on any edge with `enable`=0: `cyc` and `acc` cleared, partial window discarded, no result produced.
- RUN, each edge with `enable`=1:
  - If `cyc` != 2^WIN_LOG2-1: `acc`<=`acc+b`, `cyc`<=`cyc+1`.
  - If `cyc` == 2^WIN_LOG2-1 (window end): result `r = acc+b`; `acc`<=0, `cyc`<=0. Stays in RUN; windows are back-to-back with no gap.
- Width rules:
  - `acc` is OUT_W bits and never wraps, because the maximum value is 2^WIN_LOG2.
  - `cyc` is WIN_LOG2 bits and wraps naturally at the window end.
- Output register, at window end:
  - If `!sample_valid` or (`sample_valid && sample_ready`) in that cycle: `sample_data`<=`r`, `sample_valid`<=1. Simultaneous pop and load keeps valid high with the new data.
  - Otherwise `r` is dropped, `overrun`<=1, and `sample_data` is unchanged.
- Consume with no window end: `sample_valid`<=0. `sample_data` holds its last value.
- While `sample_valid` is high, `sample_data` is stable until the handshake.
- `clear_ovr` in the same cycle as a new drop: set wins, `overrun` stays 1.
- `enable` dropping does not affect `sample_valid`/`sample_data`; a pending result remains consumable.
- `busy` = (state == RUN).

## Timing
- Reset, on an edge with `rst`=1, all outputs and state go to 0: `sample_data`=0, `sample_valid`=0, `overrun`=0, `busy`=0, FSM=IDLE, `s1`/`s2`/filter history=0. `rst` overrides every other input, including mid-window and mid-handshake.
- `cmp_in` to `b`: 2 cycles (3 with the filter).
- `enable` sampled high at edge E0:
  - `busy`=1 after E0.
  - First window covers edges E1..E(2^WIN_LOG2).
  - `sample_valid` rises after edge E(2^WIN_LOG2).
- Subsequent results every 2^WIN_LOG2 cycles.
- Output register depth is 1. A consumer must accept within 2^WIN_LOG2 cycles of `sample_valid` rising to avoid overrun.

## Configuration
- Macro `DECIM_GLITCH_FILTER_EN`.
- Defined: `b` = majority(`s2`, `h1`, `h2`), where `h1`/`h2` are the two previous `s2` values.
  - Adds 1 cycle of latency.
  - Single-cycle comparator glitches are suppressed.
- Undefined: `b = s2`, with no extra flops.
- Window and handshake behaviour are identical in both builds.

## Test plan
- WIN_LOG2=4, `cmp_in`=1 held >=3 cycles before `enable`, `sample_ready`=1 -> `sample_data`=16, `sample_valid` high 1 cycle every 16 cycles, first after E16.
- WIN_LOG2=4, `cmp_in` toggling each cycle, settled -> every result = 8; `cmp_in`=0 -> every result = 0.
- `sample_ready`=0 for 40 cycles, WIN_LOG2=4:
  - The first result is held stable.
  - The second window end sets `overrun`.
  - `clear_ovr` then clears `overrun`.
  - Pop and load in the same cycle -> `sample_valid` stays 1 with the new value.
- `enable` dropped at `cyc`=9:
  - `busy`=0 next cycle, no result produced.
  - Re-enable -> next result counts a full fresh window.
- `rst` asserted mid-window with `sample_valid`=1 and `overrun`=1 -> all outputs 0 on the next edge.
- With the macro defined, `cmp_in`=0 with a 1-cycle high glitch each window -> results 0. Without the macro -> results 1.

Source files
------------

// File: rtl/digiota_decimator.sv
`default_nettype none
// ===========================================================================
// digiota_decimator : synchronizes the comparator bit and counts ones over
// 2^WIN_LOG2-cycle windows into a 1-deep valid/ready result register.
// Optional majority glitch filter: define DECIM_GLITCH_FILTER_EN.
// Revision: 1.0
// ===========================================================================
module digiota_decimator #(
   parameter int WIN_LOG2 = 6,
   parameter int OUT_W    = WIN_LOG2 + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmp_in,
   input  logic             enable,
   output logic [OUT_W-1:0] sample_data,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic             overrun,
   input  logic             clear_ovr,
   output logic             busy
);

   localparam logic [0:0]          ST_IDLE  = 1'b0;
   localparam logic [0:0]          ST_RUN   = 1'b1;
   localparam logic [WIN_LOG2-1:0] CYC_LAST = '1;
   localparam logic [WIN_LOG2-1:0] CYC_ONE  = WIN_LOG2'(1);

   logic                s1_q, s2_q;
   logic                bit_w;
   logic [0:0]          state_q, state_d;
   logic [WIN_LOG2-1:0] cyc_q, cyc_d;
   logic [OUT_W-1:0]    acc_q, acc_d;
   logic [OUT_W-1:0]    data_q, data_d;
   logic                valid_q, valid_d;
   logic                ovr_q, ovr_d;
   logic                win_end_w, pop_w, load_w, drop_w;
   logic [OUT_W-1:0]    result_w;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= cmp_in;
         s2_q <= s1_q;
      end
   end

`ifdef DECIM_GLITCH_FILTER_EN
   logic h1_q, h2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         h1_q <= 1'b0;
         h2_q <= 1'b0;
      end else begin
         h1_q <= s2_q;
         h2_q <= h1_q;
      end
   end

   // Majority of the last three synchronized samples rejects 1-cycle glitches
   assign bit_w = (s2_q & h1_q) | (s2_q & h2_q) | (h1_q & h2_q);
`else
   assign bit_w = s2_q;
`endif

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (enable)  state_d = ST_RUN;
         ST_RUN:  if (!enable) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = (state_q == ST_RUN);
   end

   assign win_end_w = (state_q == ST_RUN) && enable && (cyc_q == CYC_LAST);
   assign result_w  = acc_q + {{(OUT_W-1){1'b0}}, bit_w};
   assign pop_w     = valid_q && sample_ready;
   assign load_w    = win_end_w && (!valid_q || pop_w);
   assign drop_w    = win_end_w && valid_q && !sample_ready;

   // Counters are zero whenever not actively running, so a partial window
   // is discarded and every entry into RUN starts a fresh window.
   always_comb begin
      cyc_d = '0;
      acc_d = '0;
      if ((state_q == ST_RUN) && enable && !win_end_w) begin
         cyc_d = cyc_q + CYC_ONE;
         acc_d = result_w;
      end
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (load_w) begin
         data_d  = result_w;
         valid_d = 1'b1;
      end else if (pop_w) begin
         valid_d = 1'b0;
      end
      if (drop_w) begin
         ovr_d = 1'b1;
      end else if (clear_ovr) begin
         ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q   <= '0;
         acc_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         cyc_q   <= cyc_d;
         acc_q   <= acc_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign sample_data  = data_q;
   assign sample_valid = valid_q;
   assign overrun      = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_digiota_decimator.sv
`default_nettype none
// Testbench for digiota_decimator (WIN_LOG2=4): directed stimulus with a
// queue scoreboard drained by a handshake monitor.
module tb_digiota_decimator;

   localparam int WL  = 4;
   localparam int OW  = WL + 1;
   localparam int WIN = 16;
`ifdef DECIM_GLITCH_FILTER_EN
   localparam int GLITCH_EXP = 0;
`else
   localparam int GLITCH_EXP = 1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmp_in = 1'b0;
   logic          enable = 1'b0;
   logic          sample_ready = 1'b0;
   logic          clear_ovr = 1'b0;
   logic [OW-1:0] sample_data;
   logic          sample_valid;
   logic          overrun;
   logic          busy;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_q[$];
   int exp_v;
   logic tog = 1'b0;

   digiota_decimator #(.WIN_LOG2(WL)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmp_in       (cmp_in),
      .enable       (enable),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun),
      .clear_ovr    (clear_ovr),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (tog) cmp_in = ~cmp_in;
   endtask

   task automatic run_windows(input int n);
      enable = 1'b1;
      tick();
      repeat (n * WIN) tick();
      enable = 1'b0;
      tick();
   endtask

   // Monitor: every accepted result is compared against the scoreboard
   always @(negedge clk) begin
      if (!rst && sample_valid && sample_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_result", int'(sample_data), -1);
         end else begin
            exp_v = exp_q.pop_front();
            check("sb_data", int'(sample_data), exp_v);
         end
      end
   end

   initial begin
      // Reset with every other input active
      rst = 1'b1; enable = 1'b1; cmp_in = 1'b1; sample_ready = 1'b1; clear_ovr = 1'b1;
      repeat (3) tick();
      check("rst_data",    int'(sample_data), 0);
      check("rst_valid",   int'(sample_valid), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_busy",    int'(busy), 0);
      rst = 1'b0; enable = 1'b0; clear_ovr = 1'b0;
      repeat (3) tick();

      // All ones: 16 per window, valid for one cycle, first after E16
      repeat (3) exp_q.push_back(16);
      enable = 1'b1;
      tick();
      check("ones_busy_after_e0", int'(busy), 1);
      repeat (15) tick();
      check("ones_valid_e15", int'(sample_valid), 0);
      tick();
      check("ones_valid_e16", int'(sample_valid), 1);
      check("ones_data_e16",  int'(sample_data), 16);
      tick();
      check("ones_valid_e17", int'(sample_valid), 0);
      repeat (31) tick();
      enable = 1'b0;
      tick();
      check("ones_busy_off", int'(busy), 0);

      // Alternating input: 8 per window
      tog = 1'b1;
      repeat (4) tick();
      exp_q.push_back(8); exp_q.push_back(8);
      run_windows(2);
      tog = 1'b0;

      // All zeros
      cmp_in = 1'b0;
      repeat (3) tick();
      exp_q.push_back(0); exp_q.push_back(0);
      run_windows(2);

      // Back-pressure: hold, overrun, clear, pop-and-load
      cmp_in = 1'b1; sample_ready = 1'b0;
      repeat (3) tick();
      exp_q.push_back(16); exp_q.push_back(0);
      enable = 1'b1;
      tick();
      repeat (16) tick();
      check("bp_valid_e16", int'(sample_valid), 1);
      check("bp_data_e16",  int'(sample_data), 16);
      repeat (4) tick();
      cmp_in = 1'b0;
      repeat (4) tick();
      check("bp_data_held",   int'(sample_data), 16);
      check("bp_ovr_pre",     int'(overrun), 0);
      repeat (8) tick();
      check("bp_ovr_set",     int'(overrun), 1);
      check("bp_data_kept",   int'(sample_data), 16);
      clear_ovr = 1'b1;
      tick();
      clear_ovr = 1'b0;
      check("bp_ovr_clear",   int'(overrun), 0);
      repeat (14) tick();
      sample_ready = 1'b1;
      tick();
      check("bp_popload_valid", int'(sample_valid), 1);
      check("bp_popload_data",  int'(sample_data), 0);
      check("bp_popload_ovr",   int'(overrun), 0);
      enable = 1'b0;
      tick();
      check("bp_consumed", int'(sample_valid), 0);

      // Abort at cyc=9, then a fresh full window
      cmp_in = 1'b1;
      repeat (3) tick();
      enable = 1'b1;
      tick();
      repeat (9) tick();
      enable = 1'b0;
      tick();
      check("abort_busy", int'(busy), 0);
      repeat (20) tick();
      check("abort_no_result", int'(sample_valid), 0);
      exp_q.push_back(16);
      run_windows(1);

      // One-cycle glitch per window
      cmp_in = 1'b0;
      repeat (3) tick();
      exp_q.push_back(GLITCH_EXP); exp_q.push_back(GLITCH_EXP);
      enable = 1'b1;
      tick();
      for (int w = 0; w < 2; w++) begin
         repeat (5) tick();
         cmp_in = 1'b1;
         tick();
         cmp_in = 1'b0;
         repeat (10) tick();
      end
      enable = 1'b0;
      tick();

      // Reset mid-window with a pending result and overrun set
      cmp_in = 1'b1; sample_ready = 1'b0;
      repeat (3) tick();
      enable = 1'b1;
      tick();
      repeat (32) tick();
      check("mrst_pre_valid", int'(sample_valid), 1);
      check("mrst_pre_ovr",   int'(overrun), 1);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      check("mrst_data",    int'(sample_data), 0);
      check("mrst_valid",   int'(sample_valid), 0);
      check("mrst_overrun", int'(overrun), 0);
      check("mrst_busy",    int'(busy), 0);
      enable = 1'b0; rst = 1'b0;
      tick();
      check("mrst_idle", int'(busy), 0);

      check("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
